// File: rtl/mult_share_arbiter_if.sv
// Handshake and operand bundle between two requesters, a response consumer
// and the shared-multiplier arbiter.
interface mult_share_arbiter_if #(
    parameter int N = 32,
    parameter int K = 64
);
    logic         req0;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic         gnt0;
    logic         req1;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         gnt1;
    logic         rsp_valid;
    logic         rsp_id;
    logic [K-1:0] rsp_data;
    logic         rsp_ready;
    logic         busy;

    modport master (
        output req0, a0, b0, req1, a1, b1, rsp_ready,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1, rsp_ready,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one combinational N x N multiplier between two
// requesters. Operands are held for SETTLE cycles before the product is
// captured and returned over a valid/ready response channel.
module mult_share_arbiter #(
    parameter int N      = 32,
    parameter int K      = 64,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [3:0]   cnt;
    logic         prio;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [K-1:0] product;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         rsp_valid;
    logic         rsp_id;
    logic [K-1:0] rsp_data;

    // Multiplier array; held at zero while reset is asserted
    always_comb begin
        product = '0;
        if (reset)
            product = K'(op_a) * K'(op_b);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: any request in IDLE is always granted to exactly one side
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req0 || bus.req1) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd1)          state_nxt = DONE;
            DONE:    if (bus.rsp_ready)        state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Grants only in IDLE (and never while reset is asserted); prio breaks ties
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        busy = (state != IDLE);
        if (state == IDLE && reset) begin
            gnt0 = bus.req0 & (~bus.req1 | ~prio);
            gnt1 = bus.req1 & (~bus.req0 |  prio);
        end
    end

    // Operand latch, settle countdown, product capture and response hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            prio      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0) begin
                        op_a   <= bus.a0;
                        op_b   <= bus.b0;
                        rsp_id <= 1'b0;
                        cnt    <= 4'(SETTLE);
                    end else if (gnt1) begin
                        op_a   <= bus.a1;
                        op_b   <= bus.b1;
                        rsp_id <= 1'b1;
                        cnt    <= 4'(SETTLE);
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_data  <= product;
                        rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid <= 1'b0;
                        prio      <= ~rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.busy      = busy;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_data;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: scoreboard of hand-computed responses,
// checked by an independent monitor on each accepted response.
module tb_mult_share_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N(32), .K(64)) bus ();
    mult_share_arbiter_if #(.N(32), .K(64)) bus_s1 ();
    mult_share_arbiter_if #(.N(32), .K(64)) bus_s15 ();

    mult_share_arbiter #(.N(32), .K(64), .SETTLE(2))  dut     (.clk(clk), .reset(reset), .bus(bus));
    mult_share_arbiter #(.N(32), .K(64), .SETTLE(1))  dut_s1  (.clk(clk), .reset(reset), .bus(bus_s1));
    mult_share_arbiter #(.N(32), .K(64), .SETTLE(15)) dut_s15 (.clk(clk), .reset(reset), .bus(bus_s15));

    typedef struct {
        bit          id;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted response must match the oldest expected entry
    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", {63'd0, bus.rsp_id}, {63'd0, e.id});
                check("rsp_data", bus.rsp_data, e.data);
            end
        end
    end

    task automatic push(input bit id, input logic [63:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b);
        int c = 0;
        if (id == 1'b0) begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
        else            begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
        #1;
        while (!(id ? bus.gnt1 : bus.gnt0) && c < 100) begin
            tick();
            #1;
            c++;
        end
        check("grant_wait", {63'd0, c < 100}, 64'd1);
        tick();
        if (id == 1'b0) bus.req0 = 1'b0;
        else            bus.req1 = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while (sb.size() != 0 && c < 200) begin
            tick();
            c++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        tick();
    endtask

    initial begin
        int n;
        int g0;
        int g1;

        reset = 1'b0;
        {bus.req0, bus.req1, bus.a0, bus.b0, bus.a1, bus.b1} = '0;
        {bus_s1.req0, bus_s1.req1, bus_s1.a0, bus_s1.b0, bus_s1.a1, bus_s1.b1} = '0;
        {bus_s15.req0, bus_s15.req1, bus_s15.a0, bus_s15.b0, bus_s15.a1, bus_s15.b1} = '0;
        bus.rsp_ready     = 1'b1;
        bus_s1.rsp_ready  = 1'b1;
        bus_s15.rsp_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_id",    {63'd0, bus.rsp_id},    64'd0);
        check("rst_data",  bus.rsp_data,           64'd0);
        check("rst_busy",  {63'd0, bus.busy},      64'd0);
        check("rst_gnt0",  {63'd0, bus.gnt0},      64'd0);
        check("rst_gnt1",  {63'd0, bus.gnt1},      64'd0);
        reset = 1'b1;
        tick();

        // Single request 3*5, latency of 2 edges
        push(1'b0, 64'd15);
        bus.req0 = 1'b1; bus.a0 = 32'd3; bus.b0 = 32'd5;
        #1;
        check("t1_gnt0", {63'd0, bus.gnt0}, 64'd1);
        check("t1_gnt1", {63'd0, bus.gnt1}, 64'd0);
        tick();
        check("t1_gnt0_pulse", {63'd0, bus.gnt0}, 64'd0);
        check("t1_busy", {63'd0, bus.busy}, 64'd1);
        bus.req0 = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", 64'(n), 64'd2);
        drain();

        // Both requesters held: alternation 0,1,0,1 from prio=0
        do_reset();
        push(1'b0, 64'd63);
        push(1'b1, 64'h1_FFFF_FFFE);
        push(1'b0, 64'd63);
        push(1'b1, 64'h1_FFFF_FFFE);
        bus.a0 = 32'd7;          bus.b0 = 32'd9;
        bus.a1 = 32'hFFFF_FFFF;  bus.b1 = 32'd2;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        g0 = 0; g1 = 0;
        for (int c = 0; c < 200 && !(g0 == 2 && g1 == 2); c++) begin
            #1;
            if (bus.gnt0) g0++;
            if (bus.gnt1) g1++;
            if (bus.gnt0 || bus.gnt1)
                check("t2_gnt_excl", {63'd0, bus.gnt0 & bus.gnt1}, 64'd0);
            tick();
            if (g0 == 2) bus.req0 = 1'b0;
            if (g1 == 2) bus.req1 = 1'b0;
        end
        check("t2_g0", 64'(g0), 64'd2);
        check("t2_g1", 64'(g1), 64'd2);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        drain();

        // Extremes
        push(1'b0, 64'hFFFF_FFFE_0000_0001);
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        push(1'b1, 64'd0);
        issue(1'b1, 32'd0, 32'hFFFF_FFFF);
        drain();

        // Backpressure: response held stable, no grants, busy high
        bus.rsp_ready = 1'b0;
        push(1'b1, 64'h1_0001_0000);
        issue(1'b1, 32'h0001_0000, 32'h0001_0001);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        bus.req0 = 1'b1; bus.a0 = 32'd3; bus.b0 = 32'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("t4_data",  bus.rsp_data,           64'h1_0001_0000);
            check("t4_id",    {63'd0, bus.rsp_id},    64'd1);
            check("t4_gnt0",  {63'd0, bus.gnt0},      64'd0);
            check("t4_busy",  {63'd0, bus.busy},      64'd1);
        end
        bus.req0 = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        // Reset mid-BUSY after prio was moved to 1
        push(1'b0, 64'd15);
        issue(1'b0, 32'd3, 32'd5);
        drain();
        issue(1'b1, 32'd11, 32'd13);
        reset = 1'b0;
        #1;
        check("t5_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("t5_id",    {63'd0, bus.rsp_id},    64'd0);
        check("t5_data",  bus.rsp_data,           64'd0);
        check("t5_busy",  {63'd0, bus.busy},      64'd0);
        check("t5_gnt0",  {63'd0, bus.gnt0},      64'd0);
        check("t5_gnt1",  {63'd0, bus.gnt1},      64'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        end
        push(1'b0, 64'd15);
        push(1'b1, 64'd63);
        bus.req0 = 1'b1; bus.a0 = 32'd3; bus.b0 = 32'd5;
        bus.req1 = 1'b1; bus.a1 = 32'd7; bus.b1 = 32'd9;
        #1;
        check("t5_prio_gnt0", {63'd0, bus.gnt0}, 64'd1);
        check("t5_prio_gnt1", {63'd0, bus.gnt1}, 64'd0);
        tick();
        bus.req0 = 1'b0;
        n = 0;
        #1;
        while (!bus.gnt1 && n < 50) begin
            tick();
            #1;
            n++;
        end
        check("t5_gnt1_wait", {63'd0, n < 50}, 64'd1);
        tick();
        bus.req1 = 1'b0;
        drain();

        // SETTLE=1 and SETTLE=15 latency
        bus_s1.req0 = 1'b1; bus_s1.a0 = 32'd2; bus_s1.b0 = 32'd3;
        #1;
        check("s1_gnt", {63'd0, bus_s1.gnt0}, 64'd1);
        tick();
        bus_s1.req0 = 1'b0;
        n = 0;
        while (!bus_s1.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("s1_latency", 64'(n), 64'd1);
        check("s1_data", bus_s1.rsp_data, 64'd6);
        tick();

        bus_s15.req0 = 1'b1; bus_s15.a0 = 32'd2; bus_s15.b0 = 32'd3;
        #1;
        check("s15_gnt", {63'd0, bus_s15.gnt0}, 64'd1);
        tick();
        bus_s15.req0 = 1'b0;
        n = 0;
        while (!bus_s15.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("s15_latency", 64'(n), 64'd15);
        check("s15_data", bus_s15.rsp_data, 64'd6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
